// File: rtl/param_seq_detector_if.sv
// Stream/control bundle for param_seq_detector.
//   master : drives in_valid, in_seq, overlap_en, pat_load, pat_in, cnt_clr;
//            observes det_out, det_out_q, match_cnt, busy.
//   slave  : the detector side (directions reversed).
interface param_seq_detector_if #(
  parameter int unsigned PAT_LEN = 5,
  parameter int unsigned CNT_W   = 8
);
  logic               in_valid;
  logic               in_seq;
  logic               overlap_en;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               cnt_clr;
  logic               det_out;
  logic               det_out_q;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;

  modport master (
    output in_valid, in_seq, overlap_en, pat_load, pat_in, cnt_clr,
    input  det_out, det_out_q, match_cnt, busy
  );

  modport slave (
    input  in_valid, in_seq, overlap_en, pat_load, pat_in, cnt_clr,
    output det_out, det_out_q, match_cnt, busy
  );
endinterface

// File: rtl/param_seq_detector.sv
// Runtime-loadable serial pattern detector.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : param_seq_detector_if.slave
//          inputs  in_valid, in_seq, overlap_en, pat_load, pat_in, cnt_clr
//          outputs det_out (Mealy), det_out_q (registered), match_cnt (saturating), busy
module param_seq_detector #(
  parameter int unsigned        PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PAT_RST = 5'b10110,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  param_seq_detector_if.slave   bus
);

  localparam int unsigned FillW = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic               det_q, det_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               match;
  logic [PAT_LEN-1:0] window;

  // Window = stored history plus the bit on the wire; only meaningful once full.
  assign window = {hist_q, bus.in_seq};
  assign accept = bus.in_valid && !bus.pat_load;
  assign match  = !rst && accept && (fill_q == FillMax) && (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = match;
    cnt_d  = cnt_q;

    if (bus.pat_load) begin
      // Load discards the concurrent bit and restarts matching from scratch.
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      if (match && !bus.overlap_en) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_LEN-2:0];
        fill_d = (fill_q == FillMax) ? FillMax : fill_q + 1'b1;
      end
    end

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (match && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.det_out   = match;
  assign bus.det_out_q = det_q;
  assign bus.match_cnt = cnt_q;
  assign bus.busy      = (fill_q != '0);

endmodule

// File: tb/tb_param_seq_detector.sv
module tb_param_seq_detector;
  localparam int PL = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_seq = 1'b0, overlap_en = 1'b1, pat_load = 1'b0, cnt_clr = 1'b0;
  logic [PL-1:0] pat_in = '0;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  param_seq_detector_if #(.PAT_LEN(PL), .CNT_W(8)) if8 ();
  param_seq_detector_if #(.PAT_LEN(PL), .CNT_W(2)) if2 ();

  assign if8.in_valid = in_valid;   assign if2.in_valid = in_valid;
  assign if8.in_seq = in_seq;       assign if2.in_seq = in_seq;
  assign if8.overlap_en = overlap_en; assign if2.overlap_en = overlap_en;
  assign if8.pat_load = pat_load;   assign if2.pat_load = pat_load;
  assign if8.pat_in = pat_in;       assign if2.pat_in = pat_in;
  assign if8.cnt_clr = cnt_clr;     assign if2.cnt_clr = cnt_clr;

  param_seq_detector #(.PAT_LEN(PL), .PAT_RST(5'b10110), .CNT_W(8)) dut8 (
    .clk (clk), .rst (rst), .bus (if8)
  );
  param_seq_detector #(.PAT_LEN(PL), .PAT_RST(5'b10110), .CNT_W(2)) dut2 (
    .clk (clk), .rst (rst), .bus (if2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Accepted bits since the last restart, oldest first, trimmed to PL-1.
  bit mq[$];
  int mpat;
  bit mdq;
  int mc8, mc2;

  function automatic bit model_match();
    int w;
    if (rst || !in_valid || pat_load) return 1'b0;
    if (mq.size() < PL - 1) return 1'b0;
    w = 0;
    foreach (mq[i]) w = (w << 1) | int'(mq[i]);
    w = (w << 1) | int'(in_seq);
    return w == mpat;
  endfunction

  initial begin
    bit m;
    forever begin
      @(negedge clk);
      if (started) begin
        m = model_match();
        chk("det_out", 32'(if8.det_out), 32'(m));
        chk("det_out_w2", 32'(if2.det_out), 32'(m));
        chk("det_out_q", 32'(if8.det_out_q), 32'(mdq));
        chk("match_cnt", 32'(if8.match_cnt), 32'(mc8));
        chk("match_cnt_w2", 32'(if2.match_cnt), 32'(mc2));
        chk("busy", 32'(if8.busy), 32'(mq.size() != 0));
      end
      @(posedge clk);
      m = model_match();
      if (rst) begin
        mq.delete(); mpat = 'b10110; mdq = 1'b0; mc8 = 0; mc2 = 0; started = 1'b1;
      end else begin
        mdq = m;
        if (cnt_clr) begin
          mc8 = 0; mc2 = 0;
        end else if (m) begin
          if (mc8 < 255) mc8++;
          if (mc2 < 3) mc2++;
        end
        if (pat_load) begin
          mpat = int'(pat_in); mq.delete();
        end else if (in_valid) begin
          if (m && !overlap_en) mq.delete();
          else begin
            mq.push_back(in_seq);
            if (mq.size() > PL - 1) void'(mq.pop_front());
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Drives one cycle of inputs and returns at the following negedge.
  task automatic step(input logic v, input logic s, input logic ld = 1'b0,
                      input logic [PL-1:0] pi = '0, input logic clr = 1'b0,
                      input logic r = 1'b0);
    @(posedge clk); #1;
    in_valid = v; in_seq = s; pat_load = ld; pat_in = pi; cnt_clr = clr; rst = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] seq;
    logic [7:0] mask;
    logic [4:0] pat;
    repeat (3) @(posedge clk);

    // Overlapping detection of 10110 in 10110110.
    do_reset(); overlap_en = 1'b1;
    seq = 8'b10110110; mask = 8'b1001_0000;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq[7-i]);
      chk("ov_det", 32'(if8.det_out), 32'(mask[i]));
    end
    step(1'b0, 1'b0);
    chk("ov_det_q", 32'(if8.det_out_q), 32'd1);
    chk("ov_cnt", 32'(if8.match_cnt), 32'd2);

    // Non-overlapping: only the first occurrence.
    do_reset(); overlap_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq[7-i]);
      chk("nov_det", 32'(if8.det_out), 32'(i == 4));
      if (i == 5) chk("nov_busy", 32'(if8.busy), 32'd0);
    end
    step(1'b0, 1'b0);
    chk("nov_cnt", 32'(if8.match_cnt), 32'd1);

    // Load 11111 then seven 1s with gaps, both overlap modes.
    for (int ov = 1; ov >= 0; ov--) begin
      do_reset(); overlap_en = ov[0];
      step(1'b0, 1'b0, 1'b1, 5'b11111);
      for (int k = 0; k < 7; k++) begin
        step(1'b1, 1'b1);
        chk("ld_det", 32'(if8.det_out), (ov == 1) ? 32'(k >= 4) : 32'(k == 4));
        step(1'b0, 1'b1);
        chk("ld_gap_det", 32'(if8.det_out), 32'd0);
      end
      step(1'b0, 1'b0);
      chk("ld_cnt", 32'(if8.match_cnt), (ov == 1) ? 32'd3 : 32'd1);
    end

    // Saturation on the 2-bit counter, then clear colliding with a match.
    do_reset(); overlap_en = 1'b0; pat = 5'b10110;
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 5; i++) begin
        step(1'b1, pat[4-i]);
        if (p == 3 && i == 0) chk("sat_cnt3", 32'(if2.match_cnt), 32'd3);
      end
    end
    step(1'b0, 1'b0);
    chk("sat_cnt2", 32'(if2.match_cnt), 32'd3);
    chk("sat_cnt8", 32'(if8.match_cnt), 32'd10);
    for (int i = 0; i < 4; i++) step(1'b1, pat[4-i]);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("clr_det", 32'(if8.det_out), 32'd1);
    step(1'b0, 1'b0);
    chk("clr_cnt8", 32'(if8.match_cnt), 32'd0);
    chk("clr_cnt2", 32'(if2.match_cnt), 32'd0);

    // Reset mid-stream loses partial history.
    do_reset(); overlap_en = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, pat[4-i]);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("rst_det", 32'(if8.det_out), 32'd0);
    chk("rst_busy", 32'(if8.busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pat[4-i]);
      chk("rst_redet", 32'(if8.det_out), 32'(i == 4));
    end

    // Pattern load colliding with a completing bit.
    do_reset(); overlap_en = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, pat[4-i]);
    for (int i = 0; i < 4; i++) step(1'b1, pat[4-i]);
    step(1'b1, 1'b0, 1'b1, 5'b10110);
    chk("col_det", 32'(if8.det_out), 32'd0);
    step(1'b0, 1'b0);
    chk("col_busy", 32'(if8.busy), 32'd0);
    chk("col_cnt", 32'(if8.match_cnt), 32'd1);

    step(1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
Parametrised serial pattern detector, the next generation of the team's fixed-pattern Mealy detectors. It matches a runtime-loadable PAT_LEN-bit pattern on a qualified serial bit stream, with overlapping or non-overlapping detection selectable per cycle. It gives both a Mealy (same-cycle) and a registered (next-cycle) detect output, plus a saturating match counter. It sits directly behind serial input front-ends in protocol and test designs.

Parameters:
PAT_LEN, 5, pattern length in bits; must be at least 2.
PAT_RST, 5'b10110, pattern loaded at reset; the MSB is the first bit received.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_seq is a valid stream bit this cycle
in_seq  input  1  serial data bit
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
pat_load  input  1  load pat_in into the pattern register
pat_in  input  PAT_LEN  new pattern; MSB is the first bit received
cnt_clr  input  1  clear match_cnt
det_out  output  1  Mealy detect, combinational in the current cycle
det_out_q  output  1  registered det_out, one cycle later
match_cnt  output  CNT_W  saturating count of detections
busy  output  1  history holds at least one bit toward a match (fill != 0)

Behaviour:
- Reset (rst=1 at an edge):
  - pattern = PAT_RST.
  - history = 0.
  - fill = 0.
  - det_out_q = 0.
  - match_cnt = 0.
  - rst has priority over every other input.
- State:
  - hist[PAT_LEN-2:0] holds the last PAT_LEN-1 accepted bits, newest at the LSB.
  - fill counter (width $clog2(PAT_LEN)) counts from 0 and saturates at PAT_LEN-1.
- Accept: a bit is accepted when in_valid=1 and pat_load=0. Cycles with in_valid=0 leave all state unchanged, including fill and hist.
- Match term: match = accept AND (fill == PAT_LEN-1) AND ({hist, in_seq} == pattern).
- det_out = match. It is purely combinational from the inputs and state, with zero latency, and is 0 during rst.
- Next state on accept:
  - hist <= {hist[PAT_LEN-3:0], in_seq}.
  - fill <= min(fill+1, PAT_LEN-1).
  - Exception: if match=1 and overlap_en=0, then fill <= 0 and hist <= 0, so no bit of a detected pattern is reused.
  - If match=1 and overlap_en=1, the shift continues normally, so suffix/prefix overlap is detected naturally.
- overlap_en is sampled only in the cycle of a match; changing it mid-stream is legal.
- Pattern load (pat_load=1):
  - pattern <= pat_in.
  - fill <= 0, hist <= 0.
  - The concurrent in_seq bit is discarded; det_out = 0 that cycle.
- det_out_q <= det_out every cycle; it is a one-cycle-delayed registered copy.
- match_cnt:
  - If cnt_clr=1, match_cnt <= 0. Clear wins over a simultaneous match.
  - Else if match=1 and match_cnt != all-ones, match_cnt increments.
  - Else it holds. At all-ones it saturates; it never wraps.
- busy = (fill != 0).
- Reset mid-stream: partial history is lost. Bits arriving after rst deasserts are matched from scratch, with no carry-over.

Test Plan:
- Overlap: defaults, overlap_en=1, in_valid=1, stream 1,0,1,1,0,1,1,0. Required: det_out=1 during bits 5 and 8; det_out_q=1 in the cycles after them; match_cnt=2.
- Non-overlap: same stream, overlap_en=0. Required: det_out=1 on bit 5 only; match_cnt=1; busy=0 in the cycle after bit 5.
- Pattern load with gaps: pat_load with pat_in=5'b11111, then seven 1s interleaved with in_valid=0 cycles.
  - With overlap_en=1: det_out=1 on the 5th, 6th and 7th accepted 1s; match_cnt=3.
  - With overlap_en=0: match_cnt=1.
  - Invalid cycles never assert det_out.
- Saturation and clear: CNT_W=2, ten back-to-back 10110 patterns (non-overlap). Required: match_cnt=3 after the 3rd match and held there; cnt_clr coinciding with a match gives match_cnt=0.
- Reset mid-operation: send 1,0,1,1; assert rst for one cycle; send 0. Required: det_out=0 and busy=0 after reset. A following full 1,0,1,1,0 is detected on its 5th bit.
- Load collision: pat_load=1 together with in_valid=1 on what would be a completing bit. Required: det_out=0, match_cnt unchanged, fill=0 next cycle.
